// File: rtl/mac_table_ctrl_pkg.sv
// Shared widths, defaults and FSM encodings for the MAC table front-end.
// Defaults stand in for the table header values; instantiations override them.
package mac_table_ctrl_pkg;

    localparam int MAC_W          = 14;
    localparam int DEF_ADRESS     = 4;
    localparam int DEF_SLOTS      = 16384;
    localparam int DEF_ONE_SECOND = 125_000_000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;

endpackage

// File: rtl/mac_table_ctrl_rr_arbiter.sv
// Round-robin grant: first requester after ptr_i (mod N) wins.
// Output is one-hot and all-zero when disabled or idle.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int k = 0; k < N; k++) begin
                if (en_i && !found && req_i[k] &&
                    (k == (int'(ptr_i) + off) % N)) begin
                    found    = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mac_table_ctrl.sv
// MAC table front-end: arbitrates learn/lookup requests into the single
// table port and sequences the once-per-second aging sweep.
module mac_table_ctrl
    import mac_table_ctrl_pkg::*;
#(
    parameter int pPORTS      = 4,
    parameter int pADRESS     = DEF_ADRESS,
    parameter int pSLOTS      = DEF_SLOTS,
    parameter int pONE_SECOND = DEF_ONE_SECOND
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic [pPORTS-1:0]            i_req_valid,
    output logic [pPORTS-1:0]            o_req_ready,
    input  logic [pPORTS-1:0]            i_req_learn,
    input  logic [MAC_W*pPORTS-1:0]      i_req_sa,
    input  logic [MAC_W*pPORTS-1:0]      i_req_da,
    input  logic [pADRESS*pPORTS-1:0]    i_req_port,
    output logic                         o_rsp_valid,
    output logic [$clog2(pPORTS)-1:0]    o_rsp_id,
    output logic [pADRESS-1:0]           o_rsp_port,
    output logic                         o_tbl_we,
    output logic [MAC_W-1:0]             o_tbl_sa,
    output logic [MAC_W-1:0]             o_tbl_da,
    output logic [pADRESS-1:0]           o_tbl_port,
    input  logic [pADRESS-1:0]           i_tbl_port,
    output logic                         o_tbl_age_en,
    output logic [$clog2(pSLOTS)-1:0]    o_tbl_age_idx,
    output logic                         o_age_overrun
);

    localparam int IW = $clog2(pPORTS);
    localparam int SW = $clog2(pSLOTS);
    localparam int CW = $clog2(pONE_SECOND);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   req_id_q;
    logic [pPORTS-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            accept;

    logic [MAC_W-1:0]   sel_sa, sel_da;
    logic [pADRESS-1:0] sel_port;
    logic               sel_learn;
    logic               we_d;

    logic [CW-1:0] sec_cnt_q, sec_cnt_d;
    logic          sweep_q, sweep_d;
    logic [SW-1:0] age_idx_q, age_idx_d;
    logic          ovr_d;
    logic          wrap, step;

    rr_arbiter #(.N(pPORTS), .IW(IW)) u_arb (
        .req_i (i_req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  ((state_q == ST_IDLE) && irst_n),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign o_req_ready = gnt;
    assign accept      = |gnt;

    always_comb begin
        sel_sa    = '0;
        sel_da    = '0;
        sel_port  = '0;
        sel_learn = 1'b0;
        for (int k = 0; k < pPORTS; k++) begin
            if (gnt[k]) begin
                sel_sa    = i_req_sa[k*MAC_W +: MAC_W];
                sel_da    = i_req_da[k*MAC_W +: MAC_W];
                sel_port  = i_req_port[k*pADRESS +: pADRESS];
                sel_learn = i_req_learn[k];
            end
        end
    end

    assign we_d     = accept & sel_learn;
    assign rr_ptr_d = accept ? gnt_idx : rr_ptr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Age steps borrow the table port only in cycles the write leaves free.
    assign wrap = (sec_cnt_q == CW'(pONE_SECOND - 1));
    assign step = sweep_q && !we_d;

    always_comb begin
        sec_cnt_d = wrap ? '0 : sec_cnt_q + 1'b1;
        sweep_d   = sweep_q;
        age_idx_d = age_idx_q;
        ovr_d     = o_age_overrun;
        if (step) begin
            age_idx_d = age_idx_q + 1'b1;
            if (age_idx_q == SW'(pSLOTS - 1)) sweep_d = 1'b0;
        end
        if (wrap) begin
            sweep_d   = 1'b1;
            age_idx_d = '0;
            if (sweep_q) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= IW'(pPORTS - 1);
            req_id_q      <= '0;
            o_tbl_we      <= 1'b0;
            o_tbl_sa      <= '0;
            o_tbl_da      <= '0;
            o_tbl_port    <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= '0;
            o_rsp_port    <= '0;
            sec_cnt_q     <= '0;
            sweep_q       <= 1'b0;
            age_idx_q     <= '0;
            o_tbl_age_en  <= 1'b0;
            o_tbl_age_idx <= '0;
            o_age_overrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            o_tbl_we     <= we_d;
            if (accept) begin
                req_id_q   <= gnt_idx;
                o_tbl_sa   <= sel_sa;
                o_tbl_da   <= sel_da;
                o_tbl_port <= sel_port;
            end
            o_rsp_valid <= (state_q == ST_CAPTURE);
            if (state_q == ST_CAPTURE) begin
                o_rsp_id   <= req_id_q;
                o_rsp_port <= i_tbl_port;
            end
            sec_cnt_q     <= sec_cnt_d;
            sweep_q       <= sweep_d;
            age_idx_q     <= age_idx_d;
            o_tbl_age_en  <= step;
            if (step) o_tbl_age_idx <= age_idx_q;
            o_age_overrun <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mac_table_ctrl.sv
// Directed bench for mac_table_ctrl: lookup, learn, round-robin, aging,
// write/age collision, overrun and mid-request reset.
module tb_mac_table_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid, learn;
    logic [55:0] sa, da;
    logic [15:0] port;
    logic [3:0]  tbl_rd;

    logic [3:0]  ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_port;
    logic        we;
    logic [13:0] tsa, tda;
    logic [3:0]  tport;
    logic        age_en;
    logic [3:0]  age_idx;
    logic        ovr;

    logic [3:0]  b_ready;
    logic        b_rsp_valid;
    logic [1:0]  b_rsp_id;
    logic [3:0]  b_rsp_port;
    logic        b_we;
    logic [13:0] b_tsa, b_tda;
    logic [3:0]  b_tport;
    logic        b_age_en;
    logic [3:0]  b_age_idx;
    logic        b_ovr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int both_hits = 0;
    logic [3:0] mem [0:31];
    int exp_g [5];

    always #5 clk = ~clk;

    mac_table_ctrl #(
        .pPORTS(4), .pADRESS(4), .pSLOTS(16), .pONE_SECOND(64)
    ) dut (
        .iclk(clk), .irst_n(rst_n),
        .i_req_valid(valid), .o_req_ready(ready),
        .i_req_learn(learn), .i_req_sa(sa), .i_req_da(da),
        .i_req_port(port),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_port(rsp_port),
        .o_tbl_we(we), .o_tbl_sa(tsa), .o_tbl_da(tda),
        .o_tbl_port(tport), .i_tbl_port(tbl_rd),
        .o_tbl_age_en(age_en), .o_tbl_age_idx(age_idx),
        .o_age_overrun(ovr)
    );

    mac_table_ctrl #(
        .pPORTS(4), .pADRESS(4), .pSLOTS(16), .pONE_SECOND(10)
    ) dut_b (
        .iclk(clk), .irst_n(rst_n),
        .i_req_valid(4'd0), .o_req_ready(b_ready),
        .i_req_learn(4'd0), .i_req_sa(56'd0), .i_req_da(56'd0),
        .i_req_port(16'd0),
        .o_rsp_valid(b_rsp_valid), .o_rsp_id(b_rsp_id),
        .o_rsp_port(b_rsp_port),
        .o_tbl_we(b_we), .o_tbl_sa(b_tsa), .o_tbl_da(b_tda),
        .o_tbl_port(b_tport), .i_tbl_port(4'd0),
        .o_tbl_age_en(b_age_en), .o_tbl_age_idx(b_age_idx),
        .o_age_overrun(b_ovr)
    );

    // Table model: registered read, read-before-write.
    always @(posedge clk) begin
        tbl_rd <= mem[tda[4:0]];
        if (we) mem[tsa[4:0]] <= tport;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (we && age_en) both_hits = both_hits + 1;
    end

    initial begin
        #60000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int k, input logic l,
                           input logic [13:0] s, input logic [13:0] d,
                           input logic [3:0] p);
        learn[k]         = l;
        sa[k*14 +: 14]   = s;
        da[k*14 +: 14]   = d;
        port[k*4 +: 4]   = p;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'd0;
        mem[5]  = 4'd3;
        mem[16] = 4'd7;
        rst_n = 1'b0;
        valid = '0;
        learn = '0;
        sa    = '0;
        da    = '0;
        port  = '0;
        exp_g = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", {28'd0, ready}, 0);
        chk("rst_rsp", {25'd0, rsp_valid, rsp_id, rsp_port}, 0);
        chk("rst_tbl", {we, tsa, tda}, 0);
        chk("rst_tport", {28'd0, tport}, 0);
        chk("rst_age", {26'd0, age_en, age_idx, ovr}, 0);
        rst_n = 1'b1;

        // Short-period instance: second wrap lands mid-sweep.
        while (cyc < 19) @(negedge clk);
        chk("ovr_before", {31'd0, b_ovr}, 0);
        @(negedge clk);
        chk("ovr_set", {31'd0, b_ovr}, 1);

        // First sweep: wrap at edge 64, steps at edges 65..80.
        while (!age_en && cyc < 200) @(negedge clk);
        chk("age_first_cyc", cyc, 65);
        for (int i = 0; i < 16; i++) begin
            chk("age_en", {31'd0, age_en}, 1);
            chk("age_idx", {28'd0, age_idx}, i);
            @(negedge clk);
        end
        chk("age_done", {31'd0, age_en}, 0);

        // Single lookup from requester 2.
        set_req(2, 1'b0, 14'd0, 14'd5, 4'd0);
        valid = 4'b0100;
        #1 chk("lk_ready", {28'd0, ready}, 4'b0100);
        @(negedge clk);
        valid = '0;
        chk("lk_we", {31'd0, we}, 0);
        chk("lk_da", {18'd0, tda}, 5);
        @(negedge clk);
        chk("lk_early", {31'd0, rsp_valid}, 0);
        @(negedge clk);
        chk("lk_rsp", {25'd0, rsp_valid, rsp_id, rsp_port}, {1'b1, 2'd2, 4'd3});
        @(negedge clk);
        chk("lk_pulse", {31'd0, rsp_valid}, 0);

        // Learn with SA == DA returns the pre-write contents.
        set_req(0, 1'b1, 14'h10, 14'h10, 4'd1);
        valid = 4'b0001;
        #1 chk("ln_ready", {28'd0, ready}, 4'b0001);
        @(negedge clk);
        valid = '0;
        chk("ln_we", {31'd0, we}, 1);
        chk("ln_sa", {18'd0, tsa}, 14'h10);
        chk("ln_port", {28'd0, tport}, 1);
        @(negedge clk);
        chk("ln_we_off", {31'd0, we}, 0);
        @(negedge clk);
        chk("ln_rsp", {25'd0, rsp_valid, rsp_id, rsp_port}, {1'b1, 2'd0, 4'd7});

        set_req(1, 1'b0, 14'd0, 14'h10, 4'd0);
        valid = 4'b0010;
        #1 chk("rd_ready", {28'd0, ready}, 4'b0010);
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_rsp", {25'd0, rsp_valid, rsp_id, rsp_port}, {1'b1, 2'd1, 4'd1});
        chk("ovr_sticky", {31'd0, b_ovr}, 1);

        // Reset while in ISSUE.
        set_req(3, 1'b1, 14'h10, 14'h10, 4'd5);
        valid = 4'b1000;
        #1 chk("rs_ready", {28'd0, ready}, 4'b1000);
        @(negedge clk);
        valid = '0;
        chk("rs_issue_we", {31'd0, we}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_tbl", {we, tsa, tda}, 0);
        chk("rs_out", {25'd0, rsp_valid, rsp_id, rsp_port}, 0);
        chk("rs_bovr", {31'd0, b_ovr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rs_no_rsp", {31'd0, rsp_valid}, 0);
        end

        // Round-robin with all requesters valid.
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 14'd0, 14'd5, 4'd0);
        valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", {28'd0, ready}, 32'd1 << exp_g[k]);
            if (k > 0)
                chk("rr_rsp", {29'd0, rsp_valid, rsp_id}, {1'b1, 2'(exp_g[k-1])});
            @(negedge clk);
            chk("rr_gap1", {28'd0, ready}, 0);
            @(negedge clk);
            chk("rr_gap2", {28'd0, ready}, 0);
            @(negedge clk);
        end
        valid = '0;
        chk("rr_last", {29'd0, rsp_valid, rsp_id}, {1'b1, 2'd0});

        // Learn write lands in the middle of a sweep.
        while (!(age_en && age_idx == 4'd0) && cyc < 300) @(negedge clk);
        chk("col_start_cyc", cyc, 65);
        set_req(3, 1'b1, 14'd20, 14'd20, 4'd2);
        valid = 4'b1000;
        #1 chk("col_ready", {28'd0, ready}, 4'b1000);
        @(negedge clk);
        valid = '0;
        chk("col_we", {31'd0, we}, 1);
        chk("col_age_off", {31'd0, age_en}, 0);
        for (int off = 2; off <= 16; off++) begin
            @(negedge clk);
            chk("col_age_en", {31'd0, age_en}, 1);
            chk("col_age_idx", {28'd0, age_idx}, off - 1);
        end
        @(negedge clk);
        chk("col_end", {31'd0, age_en}, 0);
        chk("no_overlap", both_hits, 0);
        chk("a_no_ovr", {31'd0, ovr}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_table_ctrl.md
# mac_table_ctrl

Front-end controller for the MAC learning table. It arbitrates learn/lookup requests from pPORTS ingress port engines round-robin and sequences each granted request into the table's single write/read port. It returns the looked-up egress port to the requester and drives the table's aging sweep: one age-decrement step per slot per second, issued only in cycles without a learn write. It sits between the ingress parsers and the MAC table, and replaces the table's free-running internal aging counter.

## Interface
Parameters:
- pPORTS, 4: number of requesters.
- pADRESS, from header.v: port-number width.
- pSLOTS, from header.v: table slots. The slot index is 14 bits wide.
- pONE_SECOND, from header.v: clock cycles per aging period.

Ports:
- iclk  in  1  clock.
- irst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  pPORTS  per-requester request valid.
- o_req_ready  out  pPORTS  one-hot grant; the request is accepted on a cycle where valid and ready are both high.
- i_req_learn  in  pPORTS  per requester: 1 = write the SA→port entry as well as look up the DA.
- i_req_sa  in  14*pPORTS  packed source MACs; requester k uses bits [14k+13:14k].
- i_req_da  in  14*pPORTS  packed destination MACs, same packing.
- i_req_port  in  pADRESS*pPORTS  packed ingress port numbers to learn.
- o_rsp_valid  out  1  one-cycle response strobe. There is no backpressure on the response.
- o_rsp_id  out  $clog2(pPORTS)  index of the requester that owns the response.
- o_rsp_port  out  pADRESS  egress port read from the table.
- o_tbl_we  out  1  table write enable.
- o_tbl_sa  out  14  table write index.
- o_tbl_da  out  14  table read index.
- o_tbl_port  out  pADRESS  table write data.
- i_tbl_port  in  pADRESS  table read data, registered inside the table with 1-cycle latency.
- o_tbl_age_en  out  1  age-step strobe.
- o_tbl_age_idx  out  $clog2(pSLOTS)  slot to decrement on an age step.
- o_age_overrun  out  1  sticky error: a new second started before the previous sweep finished.

## Operation
- The FSM has three states: IDLE → ISSUE → CAPTURE → IDLE. It accepts at most one request per 3 cycles.
- **IDLE:** o_req_ready is one-hot to the first valid requester, searching from rr_ptr+1 modulo pPORTS.
  - On acceptance, latch SA, DA, port, learn and id; set rr_ptr to the granted index; go to ISSUE.
  - With no valid requests, o_req_ready = 0.
- **ISSUE:** o_tbl_sa, o_tbl_da and o_tbl_port are registered outputs, driven from the latched request. o_tbl_we = latched learn. Go to CAPTURE.
- **CAPTURE:** register i_tbl_port into o_rsp_port, o_rsp_id = latched id, pulse o_rsp_valid; go to IDLE.
- SA == DA within one request returns the pre-write table contents, because the table reads before it writes.
- **Aging counter:** sec_cnt counts 0..pONE_SECOND-1 and wraps. On the wrap cycle it sets sweep_active and age_idx = 0.
- **Sweep:** while sweep_active, every cycle with o_tbl_we = 0 asserts o_tbl_age_en with o_tbl_age_idx = age_idx and increments age_idx.
  - After the step at index pSLOTS-1, sweep_active clears.
  - o_tbl_we and o_tbl_age_en are never high in the same cycle.
- **Overrun:** if sec_cnt wraps while sweep_active is set, set o_age_overrun and restart the sweep at index 0. o_age_overrun is cleared only by reset.
- **Reset values:** every output is 0. Internal state resets to IDLE, rr_ptr = pPORTS-1 (so requester 0 wins first), sec_cnt = 0, sweep_active = 0, age_idx = 0.
- Reset asserted mid-request drops the request without a response. Requesters must re-present it.

## Timing
- Acceptance edge E0 → o_tbl_* valid in the cycle after E0 → the table samples at E1 → i_tbl_port valid after E1 → o_rsp_valid high for the cycle after E2. Response latency is 2 cycles from acceptance.
- o_req_ready is combinational from i_req_valid, rr_ptr and state. All other outputs are registered.
- A requester may hold valid while waiting. A request is lost only if its valid is dropped before grant.
- Sweep duration is ≥ pSLOTS cycles. Each learn write in that window stretches the sweep by 1 cycle.

## Structure
- Shared package: MAC index width (14), response/request field widths, and the FSM state enum.
- One sub-module, `rr_arbiter`: pPORTS-wide round-robin grant with a pointer input and an enable.
- Aging counter and sweep logic stay inline.

## Test plan
- **Single lookup:** reset, requester 2 requests learn = 0, DA = 0x0005 with the table returning 3 → o_rsp_valid 2 cycles after accept, o_rsp_id = 2, o_rsp_port = 3, o_tbl_we never high.
- **Learn:** requester 0 requests learn = 1, SA = 0x0010, port = 1 → o_tbl_we = 1 for exactly one cycle with o_tbl_sa = 0x0010 and o_tbl_port = 1.
- **Round-robin:** all four requesters valid continuously → grants in order 0, 1, 2, 3, 0, spaced 3 cycles apart. No requester is starved.
- **Aging:** pONE_SECOND = 64, pSLOTS = 16, no requests → o_tbl_age_en for 16 consecutive cycles after the wrap, indices 0..15.
- **Collision:** a learn write occurs during a sweep → no cycle has both strobes high; the sweep ends 1 cycle later and all indices are still covered exactly once.
- **Overrun and reset:** with pONE_SECOND = 10, pSLOTS = 16 → o_age_overrun sets at the second wrap. Asserting irst_n low mid-ISSUE → all outputs 0 immediately and no o_rsp_valid after release.
